// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared types and codes for the AHB-to-APB bridge: bridge
//               state encoding, AHB response codes, APB region base and the
//               AHB transfer size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

   // Bridge sequencing states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_ERR1   = 3'd3,
      ST_ERR2   = 3'd4
   } bridge_state_t;

   // AHB response codes
   localparam logic [1:0]  HRESP_OKAY  = 2'b00;
   localparam logic [1:0]  HRESP_ERROR = 2'b01;

   // Base address of the APB peripheral region
   localparam logic [31:0] APB_BASE    = 32'h4000_0000;

   // AHB hsize encodings
   localparam logic [2:0]  HSIZE_BYTE  = 3'b000;
   localparam logic [2:0]  HSIZE_HALF  = 3'b001;
   localparam logic [2:0]  HSIZE_WORD  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/apb_strb_gen.sv
`default_nettype none
// ============================================================================
// Module      : apb_strb_gen
// Description : Combinational APB4 byte-strobe generator. Derives pstrb from
//               the AHB transfer size and the low address bits; reads always
//               produce an all-zero strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_strb_gen
   import ahb_apb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr,
   input  logic       write,
   output logic [3:0] pstrb
);

   // Lane selection by size; anything word-sized or larger enables all lanes
   always_comb begin
      pstrb = 4'b0000;
      if (write) begin
         case (hsize)
            HSIZE_BYTE: pstrb = 4'b0001 << addr;
            HSIZE_HALF: pstrb = 4'b0011 << {addr[1], 1'b0};
            default:    pstrb = 4'b1111;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_bridge
// Description : AHB-Lite slave to APB4 master bridge. Each peripheral owns a
//               2**PSLOT_W byte window selected by haddr[PSLOT_W+3:PSLOT_W].
//               Out-of-range selects and APB slave errors are returned as a
//               two-cycle AHB ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int NPSEL   = 4,
   parameter int PSLOT_W = 12
)(
   input  logic                  pll_core_cpuclk,
   input  logic                  pad_cpu_rst_b,
   // AHB slave side
   input  logic                  hsel,
   input  logic [31:0]           haddr,
   input  logic [31:0]           hwdata,
   input  logic [2:0]            hsize,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   output logic [31:0]           hrdata,
   output logic                  hready,
   output logic [1:0]            hresp,
   // APB master side
   output logic [NPSEL-1:0]      psel,
   output logic                  penable,
   output logic [31:0]           paddr,
   output logic                  pwrite,
   output logic [31:0]           pwdata,
   output logic [3:0]            pstrb,
   input  logic [NPSEL*32-1:0]   prdata,
   input  logic [NPSEL-1:0]      pready,
   input  logic [NPSEL-1:0]      pslverr
);

   localparam logic [4:0] c_npsel = 5'(NPSEL);

   bridge_state_t     r_state;
   logic [NPSEL-1:0]  r_psel;
   logic              r_penable;
   logic [31:0]       r_paddr;
   logic              r_pwrite;
   logic [31:0]       r_pwdata;
   logic [3:0]        r_pstrb;
   logic [31:0]       r_hrdata;
   logic              r_hready;
   logic [1:0]        r_hresp;

   logic [3:0]        w_idx;
   logic              w_accept;
   logic              w_slot_ok;
   logic [NPSEL-1:0]  w_psel_dec;
   logic              w_pready;
   logic              w_pslverr;
   logic [31:0]       w_prdata_sel;
   logic [3:0]        w_pstrb;
   logic              w_unused;

   // A new transfer is only taken while the bridge is presenting hready=1
   assign w_idx     = haddr[PSLOT_W+3:PSLOT_W];
   assign w_accept  = hsel & htrans[1] & ((r_state == ST_IDLE) | (r_state == ST_ERR2));
   assign w_slot_ok = ({1'b0, w_idx} < c_npsel);

   // Responses of the currently selected slave; r_psel is one-hot or zero
   assign w_pready  = |(pready  & r_psel);
   assign w_pslverr = |(pslverr & r_psel);

   // One-hot decode of the incoming peripheral index
   always_comb begin
      w_psel_dec = '0;
      for (int i = 0; i < NPSEL; i++) begin
         w_psel_dec[i] = (w_idx == 4'(i));
      end
   end

   // Read data mux driven by the active select
   always_comb begin
      w_prdata_sel = '0;
      for (int i = 0; i < NPSEL; i++) begin
         if (r_psel[i]) begin
            w_prdata_sel = w_prdata_sel | prdata[i*32 +: 32];
         end
      end
   end

   apb_strb_gen u_strb_gen (
      .hsize (hsize),
      .addr  (haddr[1:0]),
      .write (hwrite),
      .pstrb (w_pstrb)
   );

   // Bridge sequencer with registered AHB and APB outputs
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         r_state   <= ST_IDLE;
         r_psel    <= '0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_hrdata  <= '0;
         r_hready  <= 1'b1;
         r_hresp   <= HRESP_OKAY;
      end else begin
         case (r_state)
            ST_IDLE, ST_ERR2: begin
               if (w_accept) begin
                  r_hready <= 1'b0;
                  if (w_slot_ok) begin
                     r_state  <= ST_SETUP;
                     r_psel   <= w_psel_dec;
                     r_paddr  <= {haddr[31:2], 2'b00};
                     r_pwrite <= hwrite;
                     r_pstrb  <= w_pstrb;
                     r_hresp  <= HRESP_OKAY;
                  end else begin
                     r_state  <= ST_ERR1;
                     r_hresp  <= HRESP_ERROR;
                  end
               end else begin
                  r_state  <= ST_IDLE;
                  r_hready <= 1'b1;
                  r_hresp  <= HRESP_OKAY;
               end
            end
            ST_SETUP: begin
               r_pwdata  <= hwdata;
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (w_pready) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  if (w_pslverr) begin
                     r_state <= ST_ERR1;
                     r_hresp <= HRESP_ERROR;
                  end else begin
                     r_state  <= ST_IDLE;
                     r_hready <= 1'b1;
                     r_hresp  <= HRESP_OKAY;
                     if (!r_pwrite) begin
                        r_hrdata <= w_prdata_sel;
                     end
                  end
               end
            end
            ST_ERR1: begin
               r_state  <= ST_ERR2;
               r_hready <= 1'b1;
               r_hresp  <= HRESP_ERROR;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_psel    <= '0;
               r_penable <= 1'b0;
               r_hready  <= 1'b1;
               r_hresp   <= HRESP_OKAY;
            end
         endcase
      end
   end

   // hwdata only becomes valid in the AHB data phase (the SETUP cycle), so it
   // is passed straight through there and held in r_pwdata for ACCESS.
   assign pwdata  = (r_state == ST_SETUP) ? hwdata : r_pwdata;

   assign psel    = r_psel;
   assign penable = r_penable;
   assign paddr   = r_paddr;
   assign pwrite  = r_pwrite;
   assign pstrb   = r_pstrb;
   assign hrdata  = r_hrdata;
   assign hready  = r_hready;
   assign hresp   = r_hresp;

   // Burst type, protection and the seq/nonseq distinction do not affect APB
   assign w_unused = ^{hburst, hprot, htrans[0]};

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb2apb_bridge
// Description : Self-checking bench for ahb2apb_bridge: directed scenarios
//               followed by randomized transfers against a transaction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge;
   import ahb_apb_pkg::*;

   localparam int NPSEL   = 4;
   localparam int PSLOT_W = 12;

   logic                 clk;
   logic                 rst_b;
   logic                 hsel;
   logic [31:0]          haddr;
   logic [31:0]          hwdata;
   logic [2:0]           hsize;
   logic [1:0]           htrans;
   logic                 hwrite;
   logic [2:0]           hburst;
   logic [3:0]           hprot;
   logic [31:0]          hrdata;
   logic                 hready;
   logic [1:0]           hresp;
   logic [NPSEL-1:0]     psel;
   logic                 penable;
   logic [31:0]          paddr;
   logic                 pwrite;
   logic [31:0]          pwdata;
   logic [3:0]           pstrb;
   logic [NPSEL*32-1:0]  prdata;
   logic [NPSEL-1:0]     pready;
   logic [NPSEL-1:0]     pslverr;

   int                   checks;
   int                   errors;
   logic [31:0]          exp_hrdata;

   ahb2apb_bridge #(.NPSEL(NPSEL), .PSLOT_W(PSLOT_W)) dut (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst_b   (rst_b),
      .hsel            (hsel),
      .haddr           (haddr),
      .hwdata          (hwdata),
      .hsize           (hsize),
      .htrans          (htrans),
      .hwrite          (hwrite),
      .hburst          (hburst),
      .hprot           (hprot),
      .hrdata          (hrdata),
      .hready          (hready),
      .hresp           (hresp),
      .psel            (psel),
      .penable         (penable),
      .paddr           (paddr),
      .pwrite          (pwrite),
      .pwdata          (pwdata),
      .pstrb           (pstrb),
      .prdata          (prdata),
      .pready          (pready),
      .pslverr         (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte lanes touched by an access: naturally aligned group of 2**size bytes
   function automatic logic [3:0] model_strb(input logic w, input logic [2:0] sz, input logic [1:0] lo);
      int nb;
      int base;
      logic [3:0] s;
      s = 4'b0000;
      if (w) begin
         nb   = (sz == HSIZE_BYTE) ? 1 : (sz == HSIZE_HALF) ? 2 : 4;
         base = int'(lo) - (int'(lo) % nb);
         for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + nb);
      end
      return s;
   endfunction

   // One AHB transfer; entered and left on a falling edge. The caller may
   // start the next transfer right away (back-to-back) or idle first.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input int waits, input logic serr,
                       input logic [31:0] rd);
      int         idx;
      bit         valid;
      logic [3:0] e_psel;
      logic [3:0] e_strb;
      int         low;
      int         selcyc;
      int         acc;
      bit         done;
      logic [1:0] last_low_resp;
      idx    = int'(a[PSLOT_W+3:PSLOT_W]);
      valid  = (idx < NPSEL);
      e_psel = valid ? 4'(2 ** idx) : 4'b0000;
      e_strb = model_strb(w, sz, a[1:0]);
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      hsel   = 1'b1;
      htrans = 2'b10;
      if (valid) begin
         prdata[idx*32 +: 32] = rd;
         pready[idx]          = 1'b0;
         pslverr[idx]         = serr;
      end
      low = 0; selcyc = 0; acc = 0; done = 0; last_low_resp = 2'b00;
      for (int c = 0; c < 100 && !done; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 0) begin
            hsel   = 1'b0;
            htrans = 2'b00;
            hwdata = wd;
            check("first_psel", 32'(psel), 32'(e_psel));
            check("first_penable", 32'(penable), 32'd0);
         end
         if (hready === 1'b1) begin
            done = 1;
         end else begin
            low++;
            last_low_resp = hresp;
            if (psel !== '0) begin
               selcyc++;
               check("psel", 32'(psel), 32'(e_psel));
               check("paddr", paddr, {a[31:2], 2'b00});
               check("pwrite", 32'(pwrite), 32'(w));
               check("pstrb", 32'(pstrb), 32'(e_strb));
               if (penable === 1'b1) begin
                  acc++;
                  if (w) check("pwdata", pwdata, wd);
                  if (valid) pready[idx] = (acc > waits);
               end
            end
         end
      end
      check("complete", 32'(done), 32'd1);
      check("hready_low_cycles", 32'(low),
            32'(valid ? (2 + waits + (serr ? 1 : 0)) : 1));
      check("psel_cycles", 32'(selcyc), 32'(valid ? (2 + waits) : 0));
      check("final_hresp", 32'(hresp), 32'((valid && !serr) ? HRESP_OKAY : HRESP_ERROR));
      if (!valid || serr) check("err1_hresp", 32'(last_low_resp), 32'(HRESP_ERROR));
      check("final_psel", 32'(psel), 32'd0);
      check("final_penable", 32'(penable), 32'd0);
      if (valid && !serr && !w) exp_hrdata = rd;
      check("hrdata", hrdata, exp_hrdata);
      if (valid) begin
         pready[idx]  = 1'b1;
         pslverr[idx] = 1'b1;
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      exp_hrdata = 32'h0;
      rst_b      = 1'b0;
      hsel       = 1'b0;
      haddr      = 32'h0;
      hwdata     = 32'h0;
      hsize      = HSIZE_WORD;
      htrans     = 2'b00;
      hwrite     = 1'b0;
      hburst     = 3'b000;
      hprot      = 4'b0011;
      prdata     = {NPSEL{32'hBAD0_BAD0}};
      pready     = '1;
      pslverr    = '1;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_hready", 32'(hready), 32'd1);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_penable", 32'(penable), 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwrite", 32'(pwrite), 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_pstrb", 32'(pstrb), 32'd0);
      rst_b = 1'b1;

      // Word write, zero wait states, peripheral 1
      xfer(APB_BASE + 32'h1004, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 0, 1'b0, 32'h0);
      @(posedge clk); @(negedge clk);

      // Byte read with three wait states, peripheral 0
      xfer(APB_BASE + 32'h0003, 1'b0, HSIZE_BYTE, 32'h0, 3, 1'b0, 32'h11223344);
      @(posedge clk); @(negedge clk);

      // Slave error on a write to peripheral 2
      xfer(APB_BASE + 32'h2000, 1'b1, HSIZE_WORD, 32'hCAFEF00D, 0, 1'b1, 32'h0);

      // Out-of-range select straight after the error response
      xfer(APB_BASE + 32'h7000, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0);
      @(posedge clk); @(negedge clk);

      // Back-to-back: second transfer accepted in the completion cycle
      xfer(APB_BASE + 32'h3010, 1'b0, HSIZE_WORD, 32'h0, 1, 1'b0, 32'hA5A55A5A);
      xfer(APB_BASE + 32'h0102, 1'b1, HSIZE_HALF, 32'h0BAD_BEEF, 0, 1'b0, 32'h0);
      @(posedge clk); @(negedge clk);

      // Reset asserted during ACCESS
      haddr  = APB_BASE + 32'h1008;
      hwrite = 1'b1;
      hsize  = HSIZE_WORD;
      hsel   = 1'b1;
      htrans = 2'b10;
      pready[1] = 1'b0;
      @(posedge clk); @(negedge clk);
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = 32'h12345678;
      @(posedge clk); @(negedge clk);
      check("pre_rst_penable", 32'(penable), 32'd1);
      #2 rst_b = 1'b0;
      #1;
      check("arst_psel", 32'(psel), 32'd0);
      check("arst_penable", 32'(penable), 32'd0);
      check("arst_hready", 32'(hready), 32'd1);
      check("arst_hresp", 32'(hresp), 32'd0);
      check("arst_hrdata", hrdata, 32'd0);
      exp_hrdata = 32'h0;
      pready[1]  = 1'b1;
      @(negedge clk);
      rst_b = 1'b1;
      xfer(APB_BASE + 32'h1008, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h600DF00D);

      // Randomized transfers, including out-of-range selects and errors
      for (int n = 0; n < 60; n++) begin
         logic [31:0] ra;
         logic [2:0]  rsz;
         ra  = APB_BASE | (32'($urandom_range(0, 5)) << PSLOT_W)
                        | (32'($urandom_range(0, 255)) << 2)
                        | 32'($urandom_range(0, 3));
         rsz = 3'($urandom_range(0, 4));
         xfer(ra, 1'($urandom_range(0, 1)), rsz, $urandom(),
              int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), $urandom());
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
